// File: rtl/uart_pkg.sv
// Shared constants, parser state encoding and checksum helper for the UART command parser.
package uart_pkg;

    localparam logic [7:0] ACK_BYTE     = 8'h06;
    localparam logic [7:0] NAK_BYTE     = 8'h15;
    localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } parser_state_e;

    // Frame checksum: 8-bit sum of address and data, carry discarded.
    function automatic logic [7:0] frame_checksum(input logic [7:0] addr, input logic [7:0] data);
        return addr + data;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: counts while enabled, clears on request, and emits a
// single-cycle expire pulse in the cycle the count sits at TIMEOUT_CYC-1 while enabled.
module uart_gap_timer #(
    parameter  int TIMEOUT_CYC = 104166,
    localparam int CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear dominates so a byte arriving on the expiry cycle suppresses the timeout.
    assign expire_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes HDR/ADDR/DATA/CHK byte frames into register-write strobes with checksum and timeout errors.
// Optional ACK/NAK reply outputs (tx_d, tx_req) are built when UART_CMD_ACK_EN is defined.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] HDR_BYTE    = DEF_HDR_BYTE,
    parameter int         TIMEOUT_CYC = 104166
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_d,
    input  logic              rx_vld,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              chk_err,
    output logic              to_err,
`ifdef UART_CMD_ACK_EN
    output logic [7:0]        tx_d,
    output logic              tx_req,
`endif
    output logic              busy
);

    parser_state_e     state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic              chk_err_q, chk_err_d;
    logic              to_err_q, to_err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              gap_expire;
`ifdef UART_CMD_ACK_EN
    logic [7:0]        tx_d_q, tx_d_d;
    logic              tx_req_q, tx_req_d;
`endif

    assign busy = (state_q != S_IDLE);

    uart_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (rx_vld || !busy),
        .en_i    (busy && !rx_vld),
        .expire_o(gap_expire)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_en_d   = 1'b0;
        chk_err_d = 1'b0;
        to_err_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef UART_CMD_ACK_EN
        tx_d_d    = tx_d_q;
        tx_req_d  = 1'b0;
`endif
        if (rx_vld) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_d == HDR_BYTE) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_d  = rx_d;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    data_d  = rx_d;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (rx_d == frame_checksum(addr_q, data_q)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q[ADDR_W-1:0];
                        wr_data_d = data_q;
`ifdef UART_CMD_ACK_EN
                        tx_d_d    = ACK_BYTE;
                        tx_req_d  = 1'b1;
`endif
                    end else begin
                        chk_err_d = 1'b1;
`ifdef UART_CMD_ACK_EN
                        tx_d_d    = NAK_BYTE;
                        tx_req_d  = 1'b1;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (gap_expire) begin
            // Truncated frame: abandon it without touching the write outputs.
            state_d  = S_IDLE;
            to_err_d = 1'b1;
`ifdef UART_CMD_ACK_EN
            tx_d_d   = NAK_BYTE;
            tx_req_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            chk_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef UART_CMD_ACK_EN
            tx_d_q    <= '0;
            tx_req_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            chk_err_q <= chk_err_d;
            to_err_q  <= to_err_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef UART_CMD_ACK_EN
            tx_d_q    <= tx_d_d;
            tx_req_q  <= tx_req_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign chk_err = chk_err_q;
    assign to_err  = to_err_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
`ifdef UART_CMD_ACK_EN
    assign tx_d    = tx_d_q;
    assign tx_req  = tx_req_q;
`endif

endmodule
